// File: rtl/load_store_unit_if.sv
// Bundle of execute-side request/response and data-memory signals for the load/store unit.
// slave is the LSU's view; master is the view of whatever drives requests and models memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_write_data, mem_read, mem_write, mem_size
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_write_data, mem_read, mem_write, mem_size
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide data memory. Sub-word loads
// select and extend a lane; sub-word stores read-modify-write; misaligned requests error out.
module load_store_unit #(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned WORD_ADDRESSED = 1
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StResp,
        StErr
    } state_e;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        accept;
    logic        legal;
    logic        capture;
    logic [31:0] addr_map;

    function automatic logic is_legal(logic we, logic [2:0] f3, logic [1:0] a);
        logic ok;
        case (f3)
            F3B:     ok = 1'b1;
            F3H:     ok = ~a[0];
            F3W:     ok = (a == 2'b00);
            F3BU:    ok = ~we;
            F3HU:    ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] merge_lane(logic [31:0] word, logic [15:0] wdata,
                                               logic [2:0] f3, logic [1:0] lane);
        logic [31:0] res;
        res = word;
        if (f3 == F3B) begin
            res[{lane, 3'b000} +: 8] = wdata[7:0];
        end else begin
            res[{lane[1], 4'b0000} +: 16] = wdata;
        end
        return res;
    endfunction

    function automatic logic [31:0] extend(logic [31:0] word, logic [2:0] f3, logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            F3B:     res = {{24{b[7]}}, b};
            F3BU:    res = {24'h0, b};
            F3H:     res = {{16{h[15]}}, h};
            F3HU:    res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign accept  = bus.req_valid && (state_q == StIdle);
    assign legal   = is_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    // Read data is valid during the last WAIT cycle, when the counter reaches one.
    assign capture = (state_q == StWait) && (cnt_q == 3'd1);
    assign addr_map = (WORD_ADDRESSED != 0) ? {2'b00, bus.req_addr[31:2]}
                                            : {bus.req_addr[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!legal) begin
                        state_d = StErr;
                    end else if (bus.req_we && (bus.req_funct3 == F3W)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                cnt_d   = 3'(RD_LATENCY);
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (capture) begin
                    state_d = we_q ? StWr : StResp;
                end
            end
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            wdata_q     <= 16'd0;
            word_q      <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                lane_q   <= bus.req_addr[1:0];
                wdata_q  <= bus.req_wdata[15:0];
                if (legal) begin
                    mem_addr_q <= addr_map;
                    if (bus.req_we && (bus.req_funct3 == F3W)) begin
                        mem_wdata_q <= bus.req_wdata;
                    end
                end
            end
            if (capture) begin
                word_q <= bus.mem_read_data;
                if (we_q) begin
                    mem_wdata_q <= merge_lane(bus.mem_read_data, wdata_q, funct3_q, lane_q);
                end
            end
        end
    end

    assign bus.req_ready      = (state_q == StIdle);
    assign bus.rsp_valid      = (state_q == StResp) || (state_q == StErr);
    assign bus.rsp_err        = (state_q == StErr);
    assign bus.rsp_rdata      = ((state_q == StResp) && !we_q) ? extend(word_q, funct3_q, lane_q)
                                                               : 32'd0;
    assign bus.mem_read       = (state_q == StRd);
    assign bus.mem_write      = (state_q == StWr);
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_size       = 3'b011;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: two LSU instances (latency 1 word-addressed, latency 3 byte-addressed)
// against behavioural memory models and a reference model of the load/store rules.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus_a ();
    load_store_unit_if bus_b ();

    load_store_unit #(.RD_LATENCY(1), .WORD_ADDRESSED(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    load_store_unit #(.RD_LATENCY(3), .WORD_ADDRESSED(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] ref_a [64];
    logic [31:0] ref_b [64];

    int          cyc = 0;
    int          rd_cnt_a = 0;
    int          wr_cnt_a = 0;
    int          both_cnt = 0;
    logic [31:0] last_rd_addr_a = 32'd0;

    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_va = 32'd0;
    logic [31:0] poke_vb = 32'd0;

    logic        pv_a = 1'b0;
    logic [31:0] pa_a = 32'd0;
    logic        pv_b [3];
    logic [31:0] pa_b [3];
    logic [31:0] noise = 32'd0;

    // Memory model: read data appears RD_LATENCY cycles after the read strobe, noise otherwise.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        noise <= $urandom;
        pv_a  <= bus_a.mem_read;
        pa_a  <= bus_a.mem_addr;
        pv_b[0] <= bus_b.mem_read;
        pa_b[0] <= bus_b.mem_addr;
        for (int i = 1; i < 3; i++) begin
            pv_b[i] <= pv_b[i-1];
            pa_b[i] <= pa_b[i-1];
        end
        if (bus_a.mem_read) begin
            rd_cnt_a       <= rd_cnt_a + 1;
            last_rd_addr_a <= bus_a.mem_addr;
        end
        if (bus_a.mem_write) begin
            wr_cnt_a <= wr_cnt_a + 1;
            mem_a[bus_a.mem_addr[5:0]] <= bus_a.mem_write_data;
        end
        if (bus_b.mem_write) mem_b[bus_b.mem_addr[7:2]] <= bus_b.mem_write_data;
        if ((bus_a.mem_read && bus_a.mem_write) || (bus_b.mem_read && bus_b.mem_write))
            both_cnt <= both_cnt + 1;
        if (poke_en) begin
            mem_a[poke_idx] <= poke_va;
            mem_b[poke_idx] <= poke_vb;
        end
    end

    assign bus_a.mem_read_data = pv_a ? mem_a[pa_a[5:0]] : noise;
    assign bus_b.mem_read_data = pv_b[2] ? mem_b[pa_b[2][7:2]] : noise;

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic f3_ok;
        if (we) f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return f3_ok && ((addr % acc_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic [31:0] v;
        v = word >> (8 * (addr % 4));
        if (acc_size(f3) == 4) return word;
        if (acc_size(f3) == 1) return f3[2] ? (v & 32'hFF) : (((v & 32'hFF) ^ 32'h80) - 32'h80);
        return f3[2] ? (v & 32'hFFFF) : (((v & 32'hFFFF) ^ 32'h8000) - 32'h8000);
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] mask;
        int          sh;
        mask = (acc_size(f3) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * acc_size(f3))) - 32'd1);
        sh   = 8 * int'(addr % 4);
        return (old & ~(mask << sh)) | ((wdata & mask) << sh);
    endfunction

    task automatic poke(input logic [5:0] idx, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_va  = va;
        poke_vb  = vb;
        ref_a[idx] = va;
        ref_b[idx] = vb;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // One request on instance A; lat counts cycles from the accept edge to rsp_valid (-1 = none).
    task automatic do_a(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr);
        int n;
        int r0;
        int w0;
        logic got;
        n = 0;
        @(negedge clk);
        while (!bus_a.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        r0 = rd_cnt_a;
        w0 = wr_cnt_a;
        bus_a.req_valid  = 1'b1;
        bus_a.req_we     = we;
        bus_a.req_funct3 = f3;
        bus_a.req_addr   = addr;
        bus_a.req_wdata  = wdata;
        @(posedge clk);
        #1 bus_a.req_valid = 1'b0;
        bus_a.req_wdata = $urandom;
        lat = 0;
        got = 1'b0;
        rdata = 32'hX;
        err = 1'bX;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus_a.rsp_valid) begin
                got   = 1'b1;
                rdata = bus_a.rsp_rdata;
                err   = bus_a.rsp_err;
            end
        end
        if (!got) lat = -1;
        nrd = rd_cnt_a - r0;
        nwr = wr_cnt_a - w0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_a.mem_read, bus_a.mem_write}
            !== 5'b10000)
            begin errors++; $display("FAIL reset_ctrl: got %b want 10000", {bus_a.req_ready,
                bus_a.rsp_valid, bus_a.rsp_err, bus_a.mem_read, bus_a.mem_write}); end
        checks++;
        if ({bus_a.rsp_rdata, bus_a.mem_addr, bus_a.mem_write_data} !== 96'd0)
            begin errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0",
                bus_a.rsp_rdata, bus_a.mem_addr, bus_a.mem_write_data); end
        checks++;
        if (bus_a.mem_size !== 3'b011 || bus_b.mem_size !== 3'b011)
            begin errors++; $display("FAIL mem_size: got %b/%b want 011", bus_a.mem_size,
                bus_b.mem_size); end
        checks++;
        if (bus_b.req_ready !== 1'b1 || bus_b.rsp_valid !== 1'b0)
            begin errors++; $display("FAIL reset_b: ready=%b valid=%b want 1/0",
                bus_b.req_ready, bus_b.rsp_valid); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic        er;
        int          lat, nrd, nwr;
        logic [2:0]  f3s [5];
        logic [31:0] adrs [5];
        logic [31:0] exps [5];
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        adrs = '{32'h16, 32'h16, 32'h16, 32'h14, 32'h14};
        exps = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        poke(6'd5, 32'h80FF_7F01, ref_b[5]);
        for (int i = 0; i < 5; i++) begin
            do_a(1'b0, f3s[i], adrs[i], 32'd0, rd, er, lat, nrd, nwr);
            checks++;
            if (rd !== exps[i] || er !== 1'b0)
                begin errors++; $display("FAIL load_vec%0d: rdata=%h err=%b want %h/0", i, rd, er,
                    exps[i]); end
            checks++;
            if (lat != 3 || nrd != 1 || nwr != 0 || last_rd_addr_a !== 32'd5)
                begin errors++; $display("FAIL load_vec%0d_timing: lat=%0d rd=%0d wr=%0d addr=%h want 3/1/0/5",
                    i, lat, nrd, nwr, last_rd_addr_a); end
        end
        poke(6'd5, 32'h1122_3344, ref_b[5]);
        do_a(1'b1, 3'b000, 32'h15, 32'h0000_00AB, rd, er, lat, nrd, nwr);
        ref_a[5] = 32'h1122_AB44;
        checks++;
        if (mem_a[5] !== 32'h1122_AB44 || er !== 1'b0 || rd !== 32'd0)
            begin errors++; $display("FAIL sb_vec: word=%h err=%b rdata=%h want 1122ab44/0/0",
                mem_a[5], er, rd); end
        checks++;
        if (lat != 4 || nrd != 1 || nwr != 1)
            begin errors++; $display("FAIL sb_timing: lat=%0d rd=%0d wr=%0d want 4/1/1", lat, nrd,
                nwr); end
        do_a(1'b1, 3'b010, 32'h18, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr);
        ref_a[6] = 32'hDEAD_BEEF;
        checks++;
        if (mem_a[6] !== 32'hDEAD_BEEF || lat != 2 || nrd != 0 || nwr != 1)
            begin errors++; $display("FAIL sw_vec: word=%h lat=%0d rd=%0d wr=%0d want deadbeef/2/0/1",
                mem_a[6], lat, nrd, nwr); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd;
        logic        er;
        int          lat, nrd, nwr;
        logic        wes  [5];
        logic [2:0]  f3s  [5];
        logic [31:0] adrs [5];
        wes  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        f3s  = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b011};
        adrs = '{32'h13, 32'h11, 32'h10, 32'h22, 32'h10};
        for (int i = 0; i < 5; i++) begin
            do_a(wes[i], f3s[i], adrs[i], $urandom, rd, er, lat, nrd, nwr);
            checks++;
            if (er !== 1'b1 || rd !== 32'd0 || lat != 1 || nrd != 0 || nwr != 0)
                begin errors++; $display("FAIL illegal%0d: err=%b rdata=%h lat=%0d rd=%0d wr=%0d want 1/0/1/0/0",
                    i, er, rd, lat, nrd, nwr); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd;
        logic        er;
        int          lat, nrd, nwr, w0;
        @(negedge clk);
        w0 = wr_cnt_a;
        bus_a.req_valid  = 1'b1;
        bus_a.req_we     = 1'b1;
        bus_a.req_funct3 = 3'b001;
        bus_a.req_addr   = 32'h22;
        bus_a.req_wdata  = 32'h0000_5A5A;
        @(posedge clk);
        #1 bus_a.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_a.mem_read, bus_a.mem_write}
            !== 5'b10000 || {bus_a.rsp_rdata, bus_a.mem_addr, bus_a.mem_write_data} !== 96'd0)
            begin errors++; $display("FAIL midop_reset_outputs: ctrl=%b addr=%h wdata=%h want 10000/0/0",
                {bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err, bus_a.mem_read, bus_a.mem_write},
                bus_a.mem_addr, bus_a.mem_write_data); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_cnt_a != w0 || mem_a[8] !== ref_a[8])
            begin errors++; $display("FAIL midop_no_write: writes=%0d word=%h want 0/%h",
                wr_cnt_a - w0, mem_a[8], ref_a[8]); end
        do_a(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, nrd, nwr);
        checks++;
        if (rd !== ref_a[8] || er !== 1'b0 || lat != 3)
            begin errors++; $display("FAIL midop_next_lw: rdata=%h err=%b lat=%0d want %h/0/3", rd,
                er, lat, ref_a[8]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, exp_rd;
        logic        er, we, ok;
        logic [2:0]  f3;
        int          lat, nrd, nwr, exp_lat;
        for (int i = 0; i < 80; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = 32'($urandom_range(0, 255));
            wdata = $urandom;
            ok    = ref_legal(we, f3, addr);
            if (!ok)                          exp_lat = 1;
            else if (we && acc_size(f3) == 4) exp_lat = 2;
            else if (we)                      exp_lat = 4;
            else                              exp_lat = 3;
            exp_rd = (ok && !we) ? ref_load(ref_a[addr[7:2]], f3, addr) : 32'd0;
            do_a(we, f3, addr, wdata, rd, er, lat, nrd, nwr);
            checks++;
            if (rd !== exp_rd || er !== !ok || lat != exp_lat)
                begin errors++; $display("FAIL rand%0d we=%b f3=%b a=%h: rdata=%h err=%b lat=%0d want %h/%b/%0d",
                    i, we, f3, addr, rd, er, lat, exp_rd, !ok, exp_lat); end
            checks++;
            if (nrd != ((ok && !(we && acc_size(f3) == 4)) ? 1 : 0) || nwr != ((ok && we) ? 1 : 0))
                begin errors++; $display("FAIL rand%0d_strobes: rd=%0d wr=%0d", i, nrd, nwr); end
            if (ok && we) begin
                ref_a[addr[7:2]] = ref_store(ref_a[addr[7:2]], f3, addr, wdata);
                checks++;
                if (mem_a[addr[7:2]] !== ref_a[addr[7:2]])
                    begin errors++; $display("FAIL rand%0d_mem: word=%h want %h", i,
                        mem_a[addr[7:2]], ref_a[addr[7:2]]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr [4];
        int          acc_cyc [4];
        int          nacc, nrsp, guard;
        nacc = 0;
        nrsp = 0;
        guard = 0;
        for (int i = 0; i < 4; i++) addr[i] = 32'(4 * $urandom_range(0, 63));
        @(negedge clk);
        bus_b.req_valid  = 1'b1;
        bus_b.req_we     = 1'b0;
        bus_b.req_funct3 = 3'b010;
        bus_b.req_addr   = addr[0];
        while (nrsp < 4 && guard < 100) begin
            if (bus_b.rsp_valid) begin
                checks++;
                if (bus_b.rsp_rdata !== ref_b[addr[nrsp][7:2]] || cyc - acc_cyc[nrsp] != 5)
                    begin errors++; $display("FAIL b2b%0d: rdata=%h lat=%0d want %h/5", nrsp,
                        bus_b.rsp_rdata, cyc - acc_cyc[nrsp], ref_b[addr[nrsp][7:2]]); end
                nrsp++;
            end else if (nacc > nrsp) begin
                checks++;
                if (bus_b.req_ready !== 1'b0)
                    begin errors++; $display("FAIL b2b_ready_low: req_ready=%b want 0",
                        bus_b.req_ready); end
            end
            if (bus_b.req_ready && bus_b.req_valid && nacc < 4) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(posedge clk);
            #1;
            if (nacc < 4) bus_b.req_addr = addr[nacc];
            else          bus_b.req_valid = 1'b0;
            @(negedge clk);
            guard++;
        end
        bus_b.req_valid = 1'b0;
        checks++;
        if (nrsp != 4)
            begin errors++; $display("FAIL b2b_timeout: responses=%0d want 4", nrsp); end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (both_cnt != 0)
            begin errors++; $display("FAIL strobe_overlap: cycles=%0d want 0", both_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_funct3 = 3'd0;
        bus_a.req_addr = 32'd0; bus_a.req_wdata = 32'd0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_funct3 = 3'd0;
        bus_b.req_addr = 32'd0; bus_b.req_wdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            pv_b[i] = 1'b0;
            pa_b[i] = 32'd0;
        end
        for (int i = 0; i < 64; i++) poke(6'(i), $urandom, $urandom);
        test_reset();
        test_directed();
        test_illegal();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
